// File: rtl/branch_pkg.sv
// Shared definitions for the branch resolve/predict slice: funct3 encodings,
// table index width and the counter reset value.
package branch_pkg;

  localparam logic [2:0] BR_BEQ  = 3'b000;
  localparam logic [2:0] BR_BNE  = 3'b001;
  localparam logic [2:0] BR_BLT  = 3'b100;
  localparam logic [2:0] BR_BGE  = 3'b101;
  localparam logic [2:0] BR_BLTU = 3'b110;
  localparam logic [2:0] BR_BGEU = 3'b111;

  function automatic int idx_w_of(input int entries);
    return $clog2(entries);
  endfunction

  // Weakly not-taken: just below the MSB threshold.
  function automatic int unsigned cnt_rst_val(input int cnt_w);
    return (32'd1 << (cnt_w - 1)) - 32'd1;
  endfunction

  function automatic logic br_legal(input logic [2:0] op);
    return (op != 3'b010) && (op != 3'b011);
  endfunction

endpackage

// File: rtl/branch_bht.sv
// Branch history table: saturating counters, one combinational read port
// (MSB only) and one write port with built-in saturating update.
module branch_bht
  import branch_pkg::*;
#(
  parameter  int ENTRIES = 64,
  parameter  int CNT_W   = 2,
  localparam int IDX_W   = idx_w_of(ENTRIES)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [IDX_W-1:0] rd_idx,
  output logic             rd_taken,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic             wr_taken
);

  localparam logic [CNT_W-1:0] RST_VAL = CNT_W'(cnt_rst_val(CNT_W));
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0] cnt_q [ENTRIES];
  logic [CNT_W-1:0] cnt_cur;
  logic [CNT_W-1:0] cnt_nxt;

  // Read-before-write: a same-cycle write is not bypassed to the read port.
  assign rd_taken = cnt_q[rd_idx][CNT_W-1];
  assign cnt_cur  = cnt_q[wr_idx];

  always_comb begin
    cnt_nxt = cnt_cur;
    if (wr_taken) begin
      if (cnt_cur != CNT_MAX) cnt_nxt = cnt_cur + CNT_W'(1);
    end else begin
      if (cnt_cur != '0) cnt_nxt = cnt_cur - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ENTRIES; i++) cnt_q[i] <= RST_VAL;
    end else if (wr_en) begin
      cnt_q[wr_idx] <= cnt_nxt;
    end
  end

endmodule

// File: rtl/branch_predict_ctlr.sv
// RV32I conditional branch resolve with BHT-based prediction, misprediction
// flagging and saturating performance counters.
module branch_predict_ctlr
  import branch_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int BHT_ENTRIES = 64,
  parameter int CNT_W       = 2,
  parameter int PERF_W      = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [XLEN-1:0]   pred_pc,
  output logic              pred_taken,
  input  logic              res_valid,
  input  logic [XLEN-1:0]   res_pc,
  input  logic [2:0]        branch_op,
  input  logic              res_pred_taken,
  input  logic              zero_flag,
  input  logic              lt_flag,
  input  logic              ltu_flag,
  output logic              pc_src,
  output logic              mispredict,
  output logic              illegal_op,
  input  logic              clear_stats,
  output logic [PERF_W-1:0] br_count,
  output logic [PERF_W-1:0] mispred_count
);

  localparam int IDX_W = idx_w_of(BHT_ENTRIES);

  logic             legal;
  logic             cond;
  logic             res_legal;
  logic [IDX_W-1:0] pred_idx;
  logic [IDX_W-1:0] res_idx;
  logic             unused_pc_bits;

  assign pred_idx = pred_pc[IDX_W+1:2];
  assign res_idx  = res_pc[IDX_W+1:2];
  assign unused_pc_bits = ^{pred_pc[XLEN-1:IDX_W+2], pred_pc[1:0],
                            res_pc[XLEN-1:IDX_W+2], res_pc[1:0]};

  always_comb begin
    cond = 1'b0;
    unique case (branch_op)
      BR_BEQ:  cond = zero_flag;
      BR_BNE:  cond = !zero_flag;
      BR_BLT:  cond = lt_flag;
      BR_BGE:  cond = !lt_flag;
      BR_BLTU: cond = ltu_flag;
      BR_BGEU: cond = !ltu_flag;
      default: cond = 1'b0;
    endcase
  end

  assign legal      = br_legal(branch_op);
  assign res_legal  = res_valid && legal;
  assign pc_src     = res_legal && cond;
  assign mispredict = res_legal && (pc_src != res_pred_taken);
  assign illegal_op = res_valid && !legal;

  branch_bht #(
    .ENTRIES (BHT_ENTRIES),
    .CNT_W   (CNT_W)
  ) u_bht (
    .clk      (clk),
    .rst_n    (rst_n),
    .rd_idx   (pred_idx),
    .rd_taken (pred_taken),
    .wr_en    (res_legal),
    .wr_idx   (res_idx),
    .wr_taken (cond)
  );

  // Counters stick at all-ones; clear wins over a same-cycle increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      br_count      <= '0;
      mispred_count <= '0;
    end else if (clear_stats) begin
      br_count      <= '0;
      mispred_count <= '0;
    end else begin
      if (res_legal && (br_count != '1))
        br_count <= br_count + PERF_W'(1);
      if (mispredict && (mispred_count != '1))
        mispred_count <= mispred_count + PERF_W'(1);
    end
  end

endmodule

// File: doc/branch_predict_ctlr.md
# branch_predict_ctlr

Parametrised successor to the single-cycle branch controller. Resolves RV32I conditional branches (all six funct3 types) from ALU compare flags, and keeps a PC-indexed branch history table (BHT) of saturating counters that supplies taken/not-taken predictions to fetch. Flags mispredictions for redirect and keeps saturating performance counters. Sits between decode/execute and the PC-select mux of the pipelined core.

## Interface
- XLEN, 32, PC width
- BHT_ENTRIES, 64, table depth; power of two, >= 2; IDX_W = log2(BHT_ENTRIES)
- CNT_W, 2, saturating counter width; >= 1
- PERF_W, 32, performance counter width
- clk  in  1  clock, rising edge
- rst_n  in  1  reset; asynchronous, active-low
- pred_pc  in  XLEN  fetch PC to predict
- pred_taken  out  1  prediction for pred_pc (combinational)
- res_valid  in  1  a branch is resolving this cycle
- res_pc  in  XLEN  PC of the resolving branch
- branch_op  in  3  RV32I funct3 of the resolving branch
- res_pred_taken  in  1  prediction originally issued for this branch
- zero_flag  in  1  rs1 == rs2
- lt_flag  in  1  rs1 < rs2 signed
- ltu_flag  in  1  rs1 < rs2 unsigned
- pc_src  out  1  resolved outcome, 1 = taken (combinational)
- mispredict  out  1  res_valid & legal & (pc_src != res_pred_taken) (combinational)
- illegal_op  out  1  res_valid & branch_op in {010, 011} (combinational)
- clear_stats  in  1  synchronous clear of performance counters
- br_count  out  PERF_W  legal resolved branches
- mispred_count  out  PERF_W  mispredictions

## Operation
- Condition: BEQ 000 → zero; BNE 001 → !zero; BLT 100 → lt; BGE 101 → !lt; BLTU 110 → ltu; BGEU 111 → !ltu; 010/011 → illegal, pc_src = 0.
- pc_src, mispredict, illegal_op are forced 0 when res_valid = 0.
- Index: idx = pc[IDX_W+1:2] for both ports; PC bits [1:0] ignored.
- pred_taken = MSB of counter[idx(pred_pc)].
- Update on rising edge when res_valid & legal: taken → counter + 1 saturating at 2^CNT_W − 1; not taken → counter − 1 saturating at 0.
- Illegal op: no table update, no counter increment.
- br_count += 1 per legal resolve; mispred_count += 1 per mispredict; both saturate at all-ones, never wrap.
- clear_stats zeroes both counters and takes priority over any same-cycle increment; BHT unaffected.

## Timing
- Reset (async assert, sync-to-clk release handled upstream): all BHT entries = 2^(CNT_W−1) − 1 (weakly not-taken; 01 for CNT_W = 2; 0 for CNT_W = 1); br_count = mispred_count = 0. Combinational outputs follow inputs during reset, with pred_taken = 0.
- Prediction and resolution outputs: zero latency, combinational.
- Table update visible to pred_taken one cycle after the resolve edge.
- Same-index read and write in one cycle: pred_taken returns the pre-update value (read-before-write, no bypass).
- One resolve per cycle; back-to-back resolves to the same index accumulate (two taken resolves from 01 → 11).
- Reset asserted mid-operation clears the table and counters immediately; in-flight resolve is discarded.

## Structure
- Shared package branch_pkg: funct3 constants BR_BEQ, BR_BNE, BR_BLT, BR_BGE, BR_BLTU, BR_BGEU; counter reset value function of CNT_W; IDX_W derivation.
- One sub-module, branch_bht: counter array with one combinational read port, one write port, and saturating update logic. Condition decode and performance counters stay in the top.

## Test plan
- After reset, each of the six ops with zero/lt/ltu = (1,0,0), then (0,1,0), then (0,0,1) → pc_src matches the truth table; ops 010/011 → illegal_op = 1, pc_src = 0, br_count unchanged.
- res_pc = 0x40 BEQ taken, three cycles → pred_taken(0x40) walks 0 → 1 → 1 → 1; counter saturates at 11. Four not-taken resolves → counter 00, pred_taken = 0.
- Aliasing: with BHT_ENTRIES = 64, PCs 0x40 and 0x140 share an entry; training one changes pred_taken of the other.
- Same cycle: pred_pc = res_pc = 0x80 taken from 01 → pred_taken = 0 that cycle, 1 the next.
- res_pred_taken = 0 with actual taken → mispredict = 1, mispred_count + 1; clear_stats in the same cycle → both counters read 0 afterwards. With PERF_W = 4, 20 resolves → br_count = 15.
- Assert rst_n low mid-training → all entries return to 01 and counters to 0 without a clock edge.
